// File: rtl/pc_if.sv
// pc_if: control inputs and PC/RAS status outputs of the fetch program-counter unit
interface pc_if #(parameter int XLEN = 32);
   logic            stall;
   logic            redirect_trap;
   logic            redirect_br;
   logic [XLEN-1:0] br_target;
   logic            call_push;
   logic            ret_pop;
   logic [XLEN-1:0] pc_out;
   logic [XLEN-1:0] pc_plus;
   logic [XLEN-1:0] pc_next;
   logic [XLEN-1:0] epc_out;
   logic            misaligned;
   logic            ras_empty;
   logic            ras_full;
   modport master (
      output stall, redirect_trap, redirect_br, br_target, call_push, ret_pop,
      input  pc_out, pc_plus, pc_next, epc_out, misaligned, ras_empty, ras_full
   );
   modport slave (
      input  stall, redirect_trap, redirect_br, br_target, call_push, ret_pop,
      output pc_out, pc_plus, pc_next, epc_out, misaligned, ras_empty, ras_full
   );
endinterface

// File: rtl/pc_unit.sv
// pc_unit: fetch PC register with prioritised next-PC select and circular return-address stack
module pc_unit #(
   parameter int              XLEN         = 32,
   parameter logic [XLEN-1:0] RESET_VECTOR = '0,
   parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int              INC          = 4,
   parameter int              ALIGN_BITS   = 2,
   parameter int              RAS_DEPTH    = 4
) (
   input logic clk,
   input logic rst_n,
   pc_if.slave bus
);
   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = PW + 1;
   logic [XLEN-1:0] pc_q, pc_d, epc_q, epc_d, pc_plus;
   logic            mis_q, mis_d;
   logic [PW-1:0]   ptr_q, ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [XLEN-1:0] ras_q [RAS_DEPTH];
   logic [XLEN-1:0] ras_d [RAS_DEPTH];
   logic            mis, trap, ras_en, push, pop, empty, full;
   assign pc_plus = pc_q + XLEN'(INC);
   assign empty   = cnt_q == '0;
   assign full    = cnt_q == CW'(RAS_DEPTH);
   assign mis     = bus.redirect_br && (bus.br_target[ALIGN_BITS-1:0] != '0);
   assign trap    = bus.redirect_trap || mis;
   assign ras_en  = !bus.stall && !trap;
   assign push    = bus.call_push && ras_en;
   assign pop     = bus.ret_pop && ras_en && !bus.redirect_br && !empty;
   always_comb begin
      pc_d  = trap ? TRAP_VECTOR : bus.stall ? pc_q : bus.redirect_br ? bus.br_target :
              (bus.ret_pop && !empty) ? ras_q[ptr_q] : pc_plus;
      epc_d = trap ? pc_q : epc_q;
      mis_d = mis && !bus.redirect_trap;
      ras_d = ras_q;
      ptr_d = ptr_q;
      cnt_d = cnt_q;
      // simultaneous call and return replaces the top in place
      if (push && pop) ras_d[ptr_q] = pc_plus;
      else if (push) begin
         ptr_d        = ptr_q + 1'b1;
         ras_d[ptr_d] = pc_plus;
         cnt_d        = full ? cnt_q : cnt_q + 1'b1;
      end else if (pop) begin
         ptr_d = ptr_q - 1'b1;
         cnt_d = cnt_q - 1'b1;
      end
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q  <= RESET_VECTOR;
         epc_q <= '0;
         mis_q <= 1'b0;
         ptr_q <= '0;
         cnt_q <= '0;
      end else begin
         pc_q  <= pc_d;
         epc_q <= epc_d;
         mis_q <= mis_d;
         ptr_q <= ptr_d;
         cnt_q <= cnt_d;
      end
   end
   always_ff @(posedge clk) ras_q <= ras_d;
   assign bus.pc_out     = pc_q;
   assign bus.pc_plus    = pc_plus;
   assign bus.pc_next    = pc_d;
   assign bus.epc_out    = epc_q;
   assign bus.misaligned = mis_q;
   assign bus.ras_empty  = empty;
   assign bus.ras_full   = full;
endmodule

// File: tb/tb_pc_unit.sv
// tb_pc_unit: directed vectors with hand-computed PC, EPC and RAS status expectations
module tb_pc_unit;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   logic [31:0] pop_exp [5] = '{32'h2C, 32'h28, 32'h24, 32'h20, 32'h24};
   pc_if #(.XLEN(32)) bus ();
   pc_unit #(.XLEN(32), .RESET_VECTOR(32'h1000)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      bus.stall = 0; bus.redirect_trap = 0; bus.redirect_br = 0;
      bus.br_target = '0; bus.call_push = 0; bus.ret_pop = 0;
   endtask
   task automatic branch(input logic [31:0] t);
      bus.redirect_br = 1; bus.br_target = t;
      tick();
      idle();
   endtask
   initial begin
      idle();
      #12;
      check("rst_pc", bus.pc_out, 32'h1000);
      check("rst_epc", bus.epc_out, 0);
      check("rst_mis", bus.misaligned, 0);
      check("rst_empty", bus.ras_empty, 1);
      check("rst_full", bus.ras_full, 0);
      rst_n = 1;
      tick(); check("seq1", bus.pc_out, 32'h1004);
      tick(); check("seq2", bus.pc_out, 32'h1008);
      tick(); check("seq3", bus.pc_out, 32'h100C);
      check("pc_plus", bus.pc_plus, 32'h1010);
      check("seq_empty", bus.ras_empty, 1);
      bus.redirect_br = 1; bus.br_target = 32'h20; #1;
      check("br_next", bus.pc_next, 32'h20);
      tick(); idle();
      check("br_pc", bus.pc_out, 32'h20);
      bus.stall = 1;
      tick(); check("stall1", bus.pc_out, 32'h20);
      tick(); check("stall2", bus.pc_out, 32'h20);
      bus.redirect_trap = 1;
      tick(); idle();
      check("trap_pc", bus.pc_out, 32'h100);
      check("trap_epc", bus.epc_out, 32'h20);
      check("trap_mis", bus.misaligned, 0);
      branch(32'h10);
      bus.redirect_br = 1; bus.br_target = 32'h42; bus.call_push = 1;
      tick(); idle();
      check("mis_pc", bus.pc_out, 32'h100);
      check("mis_epc", bus.epc_out, 32'h10);
      check("mis_pulse", bus.misaligned, 1);
      check("mis_ras", bus.ras_empty, 1);
      tick();
      check("mis_clear", bus.misaligned, 0);
      check("mis_seq", bus.pc_out, 32'h104);
      branch(32'h10);
      bus.call_push = 1; bus.redirect_br = 1; bus.br_target = 32'h80;
      tick(); idle();
      check("call_pc", bus.pc_out, 32'h80);
      check("call_empty", bus.ras_empty, 0);
      tick(); check("call_seq", bus.pc_out, 32'h84);
      bus.ret_pop = 1; #1;
      check("ret_next", bus.pc_next, 32'h14);
      tick();
      check("ret_pc", bus.pc_out, 32'h14);
      check("ret_empty", bus.ras_empty, 1);
      tick(); idle();
      check("ret_empty_seq", bus.pc_out, 32'h18);
      bus.call_push = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("ovf_pc", bus.pc_out, 32'h1C + 4 * i);
         check("ovf_full", bus.ras_full, i >= 3);
      end
      idle(); bus.ret_pop = 1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("ovf_pop", bus.pc_out, pop_exp[i]);
      end
      check("ovf_empty", bus.ras_empty, 1);
      idle(); bus.call_push = 1;
      tick();
      check("pp_pre", bus.pc_out, 32'h28);
      bus.ret_pop = 1; #1;
      check("pp_next", bus.pc_next, 32'h28);
      tick();
      check("pp_pc", bus.pc_out, 32'h28);
      check("pp_empty", bus.ras_empty, 0);
      bus.call_push = 0;
      tick(); idle();
      check("pp_pop", bus.pc_out, 32'h2C);
      check("pp_pop_empty", bus.ras_empty, 1);
      bus.stall = 1; bus.call_push = 1;
      tick(); idle();
      check("stall_push_pc", bus.pc_out, 32'h2C);
      check("stall_push_ras", bus.ras_empty, 1);
      branch(32'hFFFF_FFFC);
      check("wrap_plus", bus.pc_plus, 32'h0);
      tick();
      check("wrap_pc", bus.pc_out, 32'h0);
      #3 rst_n = 0; #1;
      check("async_pc", bus.pc_out, 32'h1000);
      check("async_epc", bus.epc_out, 0);
      check("async_empty", bus.ras_empty, 1);
      tick();
      check("async_hold", bus.pc_out, 32'h1000);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
